// File: rtl/ks_pkg.sv
// Shared constants and FSM encoding for the multi-word Kogge-Stone adder.
package ks_pkg;
  localparam int KS_WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/KS_Adder_16bit.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module KS_Adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [4:0][15:0] g;
  logic [4:0][15:0] p;
  logic [16:0]      c;

  always_comb begin
    g    = '0;
    p    = '0;
    c    = '0;
    g[0] = A & B;
    p[0] = A ^ B;
    // Four prefix levels with doubling span; after level 3 g/p cover bits [i:0].
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << s)) begin
          g[s+1][i] = g[s][i] | (p[s][i] & g[s][i-(1<<s)]);
          p[s+1][i] = p[s][i] & p[s][i-(1<<s)];
        end else begin
          g[s+1][i] = g[s][i];
          p[s+1][i] = p[s][i];
        end
      end
    end
    c[0] = Cin;
    for (int i = 0; i < 16; i++)
      c[i+1] = g[4][i] | (p[4][i] & Cin);
  end

  assign S    = p[0] ^ c[15:0];
  assign Cout = c[16];
endmodule

// File: rtl/ks_multiword_adder.sv
// Multi-precision add/sub: streams one 16-bit slice per cycle through a single
// Kogge-Stone adder, carrying between slices through a register.
module ks_multiword_adder
  import ks_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [KS_WORD_W*WORDS-1:0] A,
  input  logic [KS_WORD_W*WORDS-1:0] B,
  input  logic                    Cin,
  input  logic                    Sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [KS_WORD_W*WORDS-1:0] S,
  output logic                    Cout,
  output logic                    Ovf
);
  localparam int N  = KS_WORD_W * WORDS;
  localparam int IW = $clog2(WORDS);

  state_t                 state, state_nx;
  logic [N-1:0]           a_q, b_q;
  logic                   carry_q;
  logic [IW-1:0]          idx;
  logic [KS_WORD_W-1:0]   sl_a, sl_b, sl_s;
  logic                   sl_c;
  logic                   last;

  assign sl_a = a_q[int'(idx)*KS_WORD_W +: KS_WORD_W];
  assign sl_b = b_q[int'(idx)*KS_WORD_W +: KS_WORD_W];
  assign last = (idx == IW'(WORDS-1));

  KS_Adder_16bit u_add (
    .A    (sl_a),
    .B    (sl_b),
    .Cin  (carry_q),
    .S    (sl_s),
    .Cout (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nx = ST_RUN;
      ST_RUN:  if (last)      state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Reset gates in_ready so nothing is accepted while rst is asserted.
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_q     <= A;
          b_q     <= Sub ? ~B : B;
          carry_q <= Sub ? 1'b1 : Cin;
          idx     <= '0;
          S       <= '0;
        end
        ST_RUN: begin
          S[int'(idx)*KS_WORD_W +: KS_WORD_W] <= sl_s;
          carry_q <= sl_c;
          // Park idx at 0 so the slice mux never points past the operand.
          idx     <= last ? '0 : idx + 1'b1;
          if (last) begin
            Cout <= sl_c;
            Ovf  <= (a_q[N-1] == b_q[N-1]) && (sl_s[KS_WORD_W-1] != a_q[N-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ks_multiword_adder.sv
// Scoreboard bench for ks_multiword_adder at WORDS=4.
module tb_ks_multiword_adder;
  localparam int WORDS = 4;
  localparam int N = 16 * WORDS;

  typedef struct {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf;
  logic [N-1:0] A, B, S;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   last_accept = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ks_multiword_adder #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [N:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    e.s    = r[N-1:0];
    e.cout = r[N];
    // Add overflows on like-signed operands; subtract on unlike-signed.
    if (sub) e.ovf = (a[N-1] != b[N-1]) && (e.s[N-1] != a[N-1]);
    else     e.ovf = (a[N-1] == b[N-1]) && (e.s[N-1] != a[N-1]);
    return e;
  endfunction

  // Wait for IDLE, present operands for one accept edge, push the expectation.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_accept = cyc;
    sb.push_back(model(a, b, cin, sub));
  endtask

  // Wait for out_valid, pop the scoreboard and compare; optionally check latency.
  task automatic recv(input string name, input bit chk_lat);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles", name, n);
      return;
    end
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: result with no expectation", name);
      return;
    end
    e = sb.pop_front();
    if (S !== e.s || Cout !== e.cout || Ovf !== e.ovf) begin
      bad++;
      $display("FAIL %s: S=%h Cout=%b Ovf=%b required S=%h Cout=%b Ovf=%b",
               name, S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    if (chk_lat) begin
      total++;
      if (n !== WORDS) begin
        bad++;
        $display("FAIL %s_latency: got %0d required %0d", name, n, WORDS);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || S !== '0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b S=%h Cout=%b Ovf=%b required 0 0 0 0 0",
               in_ready, out_valid, S, Cout, Ovf);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    recv("add_slice_carry", 1'b1);
  endtask

  task automatic test_ripple();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    recv("full_ripple", 1'b1);
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    recv("ripple_cin", 1'b0);
  endtask

  task automatic test_ovf();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    recv("signed_ovf", 1'b0);
    send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    recv("sub_ovf", 1'b0);
  endtask

  task automatic test_sub();
    send(64'h0000_0000_0001_0000, 64'h1, 1'b1, 1'b1);
    recv("sub_borrow_chain", 1'b1);
    send(64'h0, 64'h1, 1'b0, 1'b1);
    recv("sub_underflow", 1'b0);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    out_ready = 1'b0;
    recv("bp_result", 1'b1);
    held = S;
    for (int i = 0; i < 6; i++) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom};
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== held) begin
        bad++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b S=%h required 1 0 %h",
                 i, out_valid, in_ready, S, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    recv("bp_next_op", 1'b1);
  endtask

  task automatic test_reset_mid_run();
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (S !== '0 || out_valid !== 1'b0 || Cout !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: S=%h out_valid=%b Cout=%b in_ready=%b required 0 0 0 0",
               S, out_valid, Cout, in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_release: in_ready=%b required 1", in_ready);
    end
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    recv("after_reset_op", 1'b1);
  endtask

  task automatic test_back_to_back();
    int t0;
    send(64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    t0 = last_accept;
    recv("b2b_first", 1'b0);
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
    total++;
    if (last_accept - t0 !== WORDS + 2) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", last_accept - t0, WORDS + 2);
    end
    recv("b2b_second", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      recv("random", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_ovf();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ks_multiword_adder.md
# ks_multiword_adder

Sequential multi-precision adder/subtractor that computes WORDS×16-bit sums by streaming one 16-bit slice per cycle through a single `KS_Adder_16bit`, registering the carry between slices. It sits directly upstream of the 16-bit Kogge-Stone adder, sequencing its operands and carry-in. It collects the slice results into a wide result word. A valid/ready handshake sits on both sides, so the block can be dropped between a register file and a writeback stage.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Operand width N = 16×WORDS; legal range 2–8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `A`  in  N  operand A, LSB slice first.
- `B`  in  N  operand B.
- `Cin`  in  1  carry-in for add; ignored when `Sub`=1.
- `Sub`  in  1  1 = compute A − B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `S`  out  N  sum/difference.
- `Cout`  out  1  carry out of MSB slice; for Sub, 1 = no borrow.
- `Ovf`  out  1  two's-complement signed overflow.

## Operation
- The state machine has three states: IDLE → RUN → DONE → IDLE.
- **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch A into `a_q`;
  - latch `Sub ? ~B : B` into `b_q`;
  - load `carry_q` = `Sub ? 1 : Cin`;
  - clear `idx`;
  - clear `S`;
  - go to RUN.
- Inputs may change freely after the accept edge.
- **RUN, each cycle:**
  - drive the adder with slice `idx` of `a_q`/`b_q` and `carry_q`;
  - write the adder sum into `S[16·idx +: 16]`;
  - load `carry_q` from the adder Cout;
  - increment `idx`.
- **Last RUN cycle (`idx`=WORDS−1):**
  - `Cout` is loaded from the adder Cout;
  - `Ovf` is loaded from (MSB of `a_q` == MSB of `b_q`) && (sum MSB != MSB of `a_q`);
  - go to DONE.
- **DONE:** `out_valid`=1; `S`, `Cout` and `Ovf` are held stable. On `out_ready`, go to IDLE.
- There is no new accept in DONE, and `in_valid` is ignored outside IDLE.
- Arithmetic is modulo 2^N. The carry chain crosses slice boundaries only through `carry_q`, with no combinational path between slices.
- **Sub semantics:** S = A + ~B + 1; `Cout`=1 iff A ≥ B unsigned.
- **Reset:**
  - state=IDLE;
  - `S`=0, `Cout`=0, `Ovf`=0, `out_valid`=0, `idx`=0, `carry_q`=0;
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after release.
- Reset asserted mid-RUN or in DONE abandons the operation. Reset wins over any simultaneous handshake.

## Timing
- Accept on edge k; RUN occupies edges k+1 … k+WORDS.
- `out_valid` rises after edge k+WORDS, i.e. latency = WORDS cycles.
- `out_valid` and `in_ready` are never high in the same cycle.
- Back-to-back throughput: one op per WORDS+2 cycles when `out_ready` is held high. The DONE cycle with `out_ready`=1 returns to IDLE on the next edge.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid`/`out_ready`.
- The critical path is one `KS_Adder_16bit` plus the slice mux, independent of WORDS.

## Structure
- The shared package `ks_pkg` holds:
  - `KS_WORD_W` = 16;
  - the state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`, 2-bit).
- `idx` width is $clog2(WORDS).
- There is exactly one sub-module instance: the existing `KS_Adder_16bit`. No other sub-modules.

## Test plan
All cases use WORDS=4 (N=64).
1. Add, A=0x0000_0000_0000_FFFF, B=0x1, Cin=0 → S=0x0000_0000_0001_0000, Cout=0, Ovf=0; `out_valid` exactly 4 cycles after accept.
2. Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → S=0, Cout=1, Ovf=0. Also A=0xAAAA_AAAA_AAAA_AAAA, B=0x5555_5555_5555_5555, Cin=1 → S=0, Cout=1.
3. Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 → S=0x8000_0000_0000_0000, Ovf=1, Cout=0.
4. Subtract, A=0x0000_0000_0001_0000, B=0x1, Sub=1, Cin=1 (ignored) → S=0x0000_0000_0000_FFFF, Cout=1. Also A=0, B=1 → S=0xFFFF_FFFF_FFFF_FFFF, Cout=0, Ovf=0.
5. Backpressure: hold `out_ready`=0 for 6 cycles in DONE while pulsing `in_valid` with new operands → S stable, `in_ready`=0, new operands not taken. Release → IDLE next cycle; the next op completes correctly.
6. Reset on the 2nd RUN cycle → next cycle S=0, `out_valid`=0, `Cout`=0; `in_ready`=1 after release; a following op (test 1 values) yields the correct result.
